// File: rtl/exhaustive_vector_sweeper_pkg.sv
// Shared types and constants for the exhaustive vector sweeper and its response compactor.
// crc_step is the reference single-bit signature update for the default 16-bit signature.
package exhaustive_vector_sweeper_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int          SIG_W_DEF    = 16;
   localparam logic [15:0] SIG_POLY_DEF = 16'h1021;
   localparam logic [15:0] SIG_SEED_DEF = 16'hFFFF;

   function automatic logic [15:0] crc_step(input logic [15:0] sig,
                                            input logic        b,
                                            input logic [15:0] poly);
      logic fb;
      fb = sig[15] ^ b;
      return {sig[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
   endfunction

endpackage

// File: rtl/exhaustive_vector_sweeper_compactor.sv
// Response compactor: ones counter plus serial CRC signature over a single-bit response stream.
// Kept separate so multi-output benchmarks can instantiate one per output.
module exhaustive_vector_sweeper_compactor
   import exhaustive_vector_sweeper_pkg::*;
#(
   parameter int               CNT_W    = 11,
   parameter int               SIG_W    = SIG_W_DEF,
   parameter logic [SIG_W-1:0] SIG_POLY = SIG_POLY_DEF,
   parameter logic [SIG_W-1:0] SIG_SEED = SIG_SEED_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             sample,
   input  logic             y_in,
   output logic [CNT_W-1:0] ones_count,
   output logic [SIG_W-1:0] signature
);

   logic [CNT_W-1:0] ones_r;
   logic [SIG_W-1:0] sig_r;

   function automatic logic [SIG_W-1:0] crc_next(input logic [SIG_W-1:0] sig, input logic b);
      logic fb;
      fb = sig[SIG_W-1] ^ b;
      return {sig[SIG_W-2:0], 1'b0} ^ (fb ? SIG_POLY : {SIG_W{1'b0}});
   endfunction

   // Counter and signature registers: cleared on reset or sweep start, updated per sample.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         ones_r <= {CNT_W{1'b0}};
         sig_r  <= SIG_SEED;
      end else if (sample) begin
         ones_r <= ones_r + CNT_W'(y_in);
         sig_r  <= crc_next(sig_r, y_in);
      end else begin
         ones_r <= ones_r;
         sig_r  <= sig_r;
      end
   end

   assign ones_count = ones_r;
   assign signature  = sig_r;

endmodule

// File: rtl/exhaustive_vector_sweeper.sv
// Drives all 2^N_IN input vectors in ascending order into a combinational benchmark and
// compacts the returned y_in stream into a ones count and a CRC signature.
module exhaustive_vector_sweeper
   import exhaustive_vector_sweeper_pkg::*;
#(
   parameter int               N_IN     = 10,
   parameter int               SIG_W    = SIG_W_DEF,
   parameter logic [SIG_W-1:0] SIG_POLY = SIG_POLY_DEF,
   parameter logic [SIG_W-1:0] SIG_SEED = SIG_SEED_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             step_en,
   output logic [N_IN-1:0]  x_out,
   input  logic             y_in,
   output logic             busy,
   output logic             done,
   output logic [N_IN:0]    ones_count,
   output logic [SIG_W-1:0] signature
);

   state_e          state_r;
   state_e          state_nxt_s;
   logic [N_IN-1:0] x_r;
   logic            start_ok_s;
   logic            step_s;
   logic            last_s;

   assign start_ok_s = start && ((state_r == IDLE) || (state_r == DONE));
   assign step_s     = (state_r == RUN) && step_en;
   assign last_s     = step_s && (x_r == {N_IN{1'b1}});

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; start is only honoured outside RUN.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE:    state_nxt_s = start ? RUN : IDLE;
         RUN:     state_nxt_s = last_s ? DONE : RUN;
         DONE:    state_nxt_s = start ? RUN : DONE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Status outputs decoded from the state register.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_r)
         IDLE:    begin busy = 1'b0; done = 1'b0; end
         RUN:     begin busy = 1'b1; done = 1'b0; end
         DONE:    begin busy = 1'b0; done = 1'b1; end
         default: begin busy = 1'b0; done = 1'b0; end
      endcase
   end

   // Vector counter; wraps to zero after the all-ones vector has been sampled.
   always_ff @(posedge clk) begin
      if (rst || start_ok_s) begin
         x_r <= {N_IN{1'b0}};
      end else if (step_s) begin
         x_r <= x_r + {{(N_IN-1){1'b0}}, 1'b1};
      end else begin
         x_r <= x_r;
      end
   end

   assign x_out = x_r;

   exhaustive_vector_sweeper_compactor #(
      .CNT_W    (N_IN + 1),
      .SIG_W    (SIG_W),
      .SIG_POLY (SIG_POLY),
      .SIG_SEED (SIG_SEED)
   ) u_compactor (
      .clk        (clk),
      .rst        (rst),
      .clr        (start_ok_s),
      .sample     (step_s),
      .y_in       (y_in),
      .ones_count (ones_count),
      .signature  (signature)
   );

endmodule

// File: tb/tb_exhaustive_vector_sweeper.sv
// Scoreboard bench for exhaustive_vector_sweeper: expected sweep results are queued at start,
// and a monitor compares them when done rises.
module tb_exhaustive_vector_sweeper;

   typedef struct {
      logic [10:0] ones;
      logic [15:0] sig;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        step_en;
   logic [9:0]  x_out;
   logic        y_in;
   logic        busy;
   logic        done;
   logic [10:0] ones_count;
   logic [15:0] signature;

   int   checks   = 0;
   int   failures = 0;
   int   mode     = 0;
   logic rnd_tbl [1024];
   exp_t exp_q [$];

   exhaustive_vector_sweeper dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .step_en    (step_en),
      .x_out      (x_out),
      .y_in       (y_in),
      .busy       (busy),
      .done       (done),
      .ones_count (ones_count),
      .signature  (signature)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Benchmark-like responses selected by mode.
   function automatic logic yfn(input int md, input logic [9:0] v);
      case (md)
         0:       return 1'b0;
         1:       return v[0];
         2:       return 1'b1;
         3:       return ((v[0] & v[3]) ^ (v[5] | v[9]) ^ (^v[8:6])) | (v == 10'h155);
         4:       return rnd_tbl[v];
         default: return 1'b0;
      endcase
   endfunction

   // Golden result: walk vectors 0..1023, count ones, divide the stream by the CRC polynomial.
   function automatic exp_t model(input int md);
      exp_t        e;
      int          cnt;
      logic [15:0] s;
      logic        y;
      cnt = 0;
      s   = 16'hFFFF;
      for (int v = 0; v < 1024; v++) begin
         y   = yfn(md, v[9:0]);
         cnt = cnt + int'(y);
         if (s[15] ^ y) s = (s << 1) ^ 16'h1021;
         else           s = s << 1;
      end
      e.ones = cnt[10:0];
      e.sig  = s;
      return e;
   endfunction

   // Combinational benchmark stand-in, refreshed once x_out has settled.
   always @(negedge clk) y_in = yfn(mode, x_out);

   logic       done_q   = 1'b0;
   logic       busy_p   = 1'b0;
   logic       step_p   = 1'b0;
   logic       rst_p    = 1'b0;
   logic [9:0] x_p      = 10'h000;
   exp_t       got;

   // Monitor: score each completed sweep and check that paused cycles hold x_out.
   always @(negedge clk) begin
      if (done === 1'b1 && done_q === 1'b0) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            got = exp_q.pop_front();
            chk("sweep_ones", 32'(ones_count), 32'(got.ones));
            chk("sweep_signature", 32'(signature), 32'(got.sig));
            chk("done_x_wrap", 32'(x_out), 32'd0);
            chk("done_busy", 32'(busy), 32'd0);
         end
      end
      if (busy_p === 1'b1 && step_p === 1'b0 && rst_p === 1'b0)
         chk("pause_hold_x", 32'(x_out), 32'(x_p));
      done_q = done;
      busy_p = busy;
      step_p = step_en;
      rst_p  = rst;
      x_p    = x_out;
   end

   task automatic start_sweep(input int md);
      mode = md;
      exp_q.push_back(model(md));
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input bit rnd_step, input int budget, output int n);
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         step_en = rnd_step ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
         n++;
      end
      step_en = 1'b1;
      if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   int n;

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      step_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_x", 32'(x_out), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_ones", 32'(ones_count), 32'd0);
      chk("reset_sig", 32'(signature), 32'hFFFF);
      rst     = 1'b0;
      step_en = 1'b1;
      @(posedge clk); #1;
      chk("idle_hold", 32'(busy), 32'd0);

      // y_in tied 0: latency and first-vector timing.
      start_sweep(0);
      chk("first_vector", 32'(x_out), 32'd0);
      chk("first_busy", 32'(busy), 32'd1);
      n = 0;
      while (done !== 1'b1 && n < 1100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("done_latency", 32'(n + 1), 32'd1025);
      @(negedge clk);
      @(posedge clk); #1;

      start_sweep(1);
      wait_done(1'b0, 1100, n);
      chk("ones_half", 32'(ones_count), 32'd512);

      start_sweep(2);
      wait_done(1'b0, 1100, n);
      chk("ones_full", 32'(ones_count), 32'h400);

      start_sweep(3);
      wait_done(1'b0, 1100, n);
      start_sweep(3);
      wait_done(1'b1, 8000, n);

      for (int i = 0; i < 1024; i++) rnd_tbl[i] = 1'($urandom_range(0, 1));
      start_sweep(4);
      wait_done(1'b1, 8000, n);

      // Reset mid-run at vector 0x155.
      start_sweep(3);
      n = 0;
      while (x_out !== 10'h155 && n < 2000) begin
         step_en = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         n++;
      end
      chk("reach_155", 32'(x_out), 32'h155);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      void'(exp_q.pop_back());
      chk("midrst_x", 32'(x_out), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_ones", 32'(ones_count), 32'd0);
      chk("midrst_sig", 32'(signature), 32'hFFFF);
      step_en = 1'b1;
      @(posedge clk); #1;
      chk("midrst_idle", 32'(busy), 32'd0);
      start_sweep(3);
      wait_done(1'b0, 1100, n);

      // start during RUN is ignored.
      start_sweep(4);
      repeat (300) begin
         step_en = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      n     = int'(x_out);
      start = 1'b1;
      step_en = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("run_start_ignored", 32'(x_out), 32'(n));
      wait_done(1'b1, 8000, n);

      // start in DONE restarts a full sweep.
      chk("done_sticky", 32'(done), 32'd1);
      start_sweep(3);
      chk("restart_done_low", 32'(done), 32'd0);
      chk("restart_x", 32'(x_out), 32'd0);
      chk("restart_busy", 32'(busy), 32'd1);
      wait_done(1'b0, 1100, n);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
